mem_arbiter: RTL and testbench

Arbiter and sequencer for the single shared multi-cycle memory used by the 5-stage pipeline. Sits between IF (instruction fetch) and MEM (LW/SW) on one side and the unified memory array on the other. Grants one requester at a time, drives the memory port for a fixed latency, and returns a one-cycle acknowledge with read data. The pipeline's stall logic uses `i_ack`, `d_ack` and `busy` to hold stages during an access.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_lat_cnt.sv | 33 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared FSM state and owner encodings for mem_arbiter |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_lat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lat_cnt : loadable down-counter for the memory access latency  |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
module mem_lat_cnt #(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(LATENCY - 1);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule : mem_lat_cnt
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : IF/MEM arbiter and sequencer for the shared memory.  |
// | Optional macro MEM_ARB_FAIRNESS_EN alternates grants on a tie.     |
// | Revision    : 1.0                                                  |
// +------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_kill,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   state_t        state;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_wdata;
   logic          hold_wr;
   logic          kill;
   logic          cnt_zero;
   logic          any_req;
   logic          tie_to_d;
   logic          grant_d;
   logic          kill_now;

   assign any_req = i_req | d_req;

`ifdef MEM_ARB_FAIRNESS_EN
   // owner doubles as the last-granted history used to break ties
   assign tie_to_d = (owner == OWN_I);
`else
   assign tie_to_d = 1'b1;
`endif

   assign grant_d  = d_req & (~i_req | tie_to_d);
   assign kill_now = kill | (i_kill & (owner == OWN_I));

   mem_lat_cnt #(
      .LATENCY (LATENCY)
   ) u_lat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  ((state == ST_IDLE) & any_req),
      .dec   (state == ST_WAIT),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= OWN_I;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_wr    <= 1'b0;
         kill       <= 1'b0;
         mem_en     <= 1'b0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         mem_en <= 1'b0;
         i_ack  <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            ST_IDLE: begin
               kill <= 1'b0;
               if (any_req) begin
                  owner      <= grant_d ? OWN_D : OWN_I;
                  hold_addr  <= grant_d ? d_addr : i_addr;
                  hold_wdata <= grant_d ? d_wdata : '0;
                  hold_wr    <= grant_d & d_wr;
                  mem_en     <= 1'b1;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (kill_now) begin
                  kill <= 1'b1;
               end
               if (cnt_zero) begin
                  if (owner == OWN_D) begin
                     d_ack <= 1'b1;
                     if (!hold_wr) begin
                        d_rdata <= mem_rdata;
                     end
                  end else if (!kill_now) begin
                     i_ack   <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               kill  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign mem_addr  = hold_addr;
   assign mem_wdata = hold_wdata;
   assign mem_wr    = hold_wr & (state == ST_WAIT);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter      |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int LATENCY = 4;
   localparam int AW      = 16;
   localparam int DW      = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req, i_kill, d_req, d_wr;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic          i_ack, d_ack, mem_en, mem_wr, busy, owner;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .LATENCY (LATENCY),
      .AW      (AW),
      .DW      (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_kill    (i_kill),
      .i_rdata   (i_rdata),
      .i_ack     (i_ack),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   // Memory contents: two fixed words, everything else is addr ^ 0xA5A5
   function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
      case (a)
         16'h0010: mem_model = 16'hB123;
         16'h0040: mem_model = 16'h00AA;
         default:  mem_model = a ^ 16'hA5A5;
      endcase
   endfunction

   always_comb mem_rdata = mem_model(mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int first_i_ack;
   int n_d_ack;

   initial begin
      rst_n   = 1'b0;
      i_req   = 1'b0;
      i_kill  = 1'b0;
      d_req   = 1'b0;
      d_wr    = 1'b0;
      i_addr  = '0;
      d_addr  = '0;
      d_wdata = '0;
      step();
      step();
      check("rst_busy",   32'(busy),     32'h0);
      check("rst_owner",  32'(owner),    32'h0);
      check("rst_memen",  32'(mem_en),   32'h0);
      check("rst_iack",   32'(i_ack),    32'h0);
      check("rst_addr",   32'(mem_addr), 32'h0);
      check("rst_irdata", 32'(i_rdata),  32'h0);
      rst_n = 1'b1;
      step();

      // Lone fetch; i_addr change after grant must be ignored
      i_req  = 1'b1;
      i_addr = 16'h0010;
      check("lone_busy0", 32'(busy), 32'h0);
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 2) i_addr = 16'hFFFF;
         check("lone_memen", 32'(mem_en), 32'(c == 1));
         check("lone_busy",  32'(busy),   32'(c <= 5));
         check("lone_iack",  32'(i_ack),  32'(c == 5));
         if (c <= 4) check("lone_addr", 32'(mem_addr), 32'h0010);
         if (c == 5) check("lone_rdata", 32'(i_rdata), 32'hB123);
         if (c == 6) i_req = 1'b0;
      end

      // Simultaneous requests: D first, then fetch
      i_req  = 1'b1;
      i_addr = 16'h0030;
      d_req  = 1'b1;
      d_wr   = 1'b0;
      d_addr = 16'h0040;
      for (int c = 1; c <= 12; c++) begin
         step();
         check("sim_memen", 32'(mem_en), 32'(c == 1 || c == 7));
         check("sim_dack",  32'(d_ack),  32'(c == 5));
         check("sim_iack",  32'(i_ack),  32'(c == 11));
         if (c == 1) check("sim_owner_d", 32'(owner), 32'h1);
         if (c == 5) check("sim_drdata", 32'(d_rdata), 32'h00AA);
         if (c == 7) check("sim_iaddr", 32'(mem_addr), 32'h0030);
         if (c == 11) check("sim_irdata", 32'(i_rdata), 32'hA595);
         if (c == 6) d_req = 1'b0;
         if (c == 12) i_req = 1'b0;
      end

      // Store: write strobes held, d_rdata untouched
      d_req   = 1'b1;
      d_wr    = 1'b1;
      d_addr  = 16'h0044;
      d_wdata = 16'hBEEF;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 2) d_wdata = 16'h0000;
         if (c <= 4) begin
            check("st_memwr",    32'(mem_wr),    32'h1);
            check("st_memwdata", 32'(mem_wdata), 32'hBEEF);
            check("st_memaddr",  32'(mem_addr),  32'h0044);
         end
         check("st_memen", 32'(mem_en), 32'(c == 1));
         check("st_dack",  32'(d_ack),  32'(c == 5));
         if (c >= 5) check("st_drdata", 32'(d_rdata), 32'h00AA);
         if (c == 6) begin
            d_req = 1'b0;
            d_wr  = 1'b0;
         end
      end

      // Kill: fetch abandoned in cycle 2, then a load is served normally
      i_req  = 1'b1;
      i_addr = 16'h0010;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 2) begin
            i_kill = 1'b1;
            i_req  = 1'b0;
         end
         if (c == 3) i_kill = 1'b0;
         check("kill_iack", 32'(i_ack), 32'h0);
         if (c <= 6) check("kill_irdata", 32'(i_rdata), 32'hA595);
         if (c == 6) begin
            check("kill_idle", 32'(busy), 32'h0);
            d_req  = 1'b1;
            d_addr = 16'h0050;
         end
         if (c >= 7) check("kill_dack", 32'(d_ack), 32'(c == 11));
         if (c == 11) check("kill_drdata", 32'(d_rdata), 32'hA5F5);
      end
      step();
      d_req = 1'b0;

      // Reset in the middle of a fetch
      i_req  = 1'b1;
      i_addr = 16'h0010;
      step();
      step();
      step();
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      check("mid_rst_busy",   32'(busy),     32'h0);
      check("mid_rst_memen",  32'(mem_en),   32'h0);
      check("mid_rst_addr",   32'(mem_addr), 32'h0);
      check("mid_rst_irdata", 32'(i_rdata),  32'h0);
      check("mid_rst_drdata", 32'(d_rdata),  32'h0);
      step();
      rst_n  = 1'b1;
      i_req  = 1'b1;
      i_addr = 16'h0030;
      for (int c = 1; c <= 6; c++) begin
         step();
         check("post_rst_iack", 32'(i_ack), 32'(c == 5));
         if (c == 5) check("post_rst_irdata", 32'(i_rdata), 32'hA595);
         if (c == 6) i_req = 1'b0;
      end

      // Fairness: continuous loads with a fetch pending from cycle 0
      first_i_ack = -1;
      n_d_ack     = 0;
      i_req  = 1'b1;
      i_addr = 16'h0010;
      d_req  = 1'b1;
      d_addr = 16'h0040;
      for (int c = 1; c <= 59; c++) begin
         step();
         if (d_ack) n_d_ack++;
         if (i_ack && first_i_ack < 0) begin
            first_i_ack = c;
            i_req = 1'b0;
         end
      end
`ifdef MEM_ARB_FAIRNESS_EN
      check("fair_iack_cycle", 32'(first_i_ack), 32'd11);
      check("fair_dacks",      32'(n_d_ack),     32'd9);
`else
      check("fair_iack_cycle", 32'(first_i_ack), 32'hFFFF_FFFF);
      check("fair_dacks",      32'(n_d_ack),     32'd10);
`endif
      i_req = 1'b0;
      d_req = 1'b0;
      for (int c = 0; c < 8; c++) step();
      check("end_idle", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
